// File: rtl/display_scan_ctrl_if.sv
// Bundles the load/blink/blanking controls and the scan outputs of display_scan_ctrl.
// The master side is the driving logic or testbench. The slave side is the scan controller.
interface display_scan_ctrl_if;
  logic [15:0] digits_in;
  logic        load;
  logic        blink_en;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [3:0]  code_out;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output digits_in, load, blink_en, blink_mask, lz_en,
    input  code_out, an, frame_tick
  );

  modport slave (
    input  digits_in, load, blink_en, blink_mask, lz_en,
    output code_out, an, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-seg scanner: a BLANK/SHOW FSM with staged tear-free loads, blink and leading-zero blanking.
// Outputs are registered on the FSM edge. There is no backpressure; a load is only ever staged until the next frame boundary.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic          pending;
  logic [15:0]   shadow;
  logic [15:0]   staging;
  logic [3:0]    code_q;
  logic [3:0]    an_q;
  logic          tick_q;

  logic [3:0]    cur_digit;
  logic          blanked;

  always_comb begin
    cur_digit = shadow[3:0];
    case (idx)
      2'd0: cur_digit = shadow[3:0];
      2'd1: cur_digit = shadow[7:4];
      2'd2: cur_digit = shadow[11:8];
      2'd3: cur_digit = shadow[15:12];
      default: cur_digit = shadow[3:0];
    endcase
  end

  // Evaluated only on SHOW entry, so control changes never disturb a lit digit.
  assign blanked = (bus.blink_en && bus.blink_mask[idx] && blink_phase) ||
                   (idx == 2'd3 && bus.lz_en && cur_digit == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      pending     <= 1'b0;
      shadow      <= 16'h0000;
      staging     <= 16'h0000;
      an_q        <= 4'b1111;
      code_q      <= 4'hF;
      tick_q      <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.load) begin
        staging <= bus.digits_in;
        pending <= 1'b1;
      end
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state  <= SHOW;
            cnt    <= '0;
            an_q   <= ~(4'b0001 << idx);
            code_q <= blanked ? 4'hF : cur_digit;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state  <= BLANK;
            cnt    <= '0;
            idx    <= idx + 2'd1;
            an_q   <= 4'b1111;
            code_q <= 4'hF;
            if (idx == 2'd3) begin
              // Frame boundary: a coincident load bypasses staging and wins.
              tick_q  <= 1'b1;
              pending <= 1'b0;
              if (bus.load)
                shadow <= bus.digits_in;
              else if (pending)
                shadow <= staging;
              if (fcnt == FRAME_LAST) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                fcnt <= fcnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.code_out   = code_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random traffic against a
// position-in-frame reference model (slot = pos / slot_len, lit when pos % slot_len >= blank length).
module tb_display_scan_ctrl;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = BC + SD;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  int          c;
  int          m_frame;
  logic [15:0] m_shadow;
  logic [15:0] m_staging;
  logic        m_pending;
  logic [3:0]  m_an;
  logic [3:0]  m_code;
  logic        m_tick;

  int vecs;
  int errs;

  // Advance one clock and update the model from the inputs presented before the edge.
  task automatic step();
    logic        r_v  = rst;
    logic        ld   = bus.load;
    logic [15:0] d    = bus.digits_in;
    logic        be   = bus.blink_en;
    logic [3:0]  bm   = bus.blink_mask;
    logic        lz   = bus.lz_en;
    int          pos, ph, slot;
    logic [3:0]  dig;
    logic        blk;
    @(posedge clk);
    if (r_v) begin
      c = 0; m_frame = 0; m_shadow = 16'h0; m_staging = 16'h0; m_pending = 1'b0;
      m_an = 4'b1111; m_code = 4'hF; m_tick = 1'b0;
    end else begin
      c++;
      pos    = c % FRAME;
      m_tick = (pos == 0);
      if (pos == 0) begin
        m_frame++;
        if (ld) m_shadow = d;
        else if (m_pending) m_shadow = m_staging;
        m_pending = 1'b0;
        if (ld) m_staging = d;
      end else if (ld) begin
        m_staging = d;
        m_pending = 1'b1;
      end
      slot = pos / SLOT;
      ph   = pos % SLOT;
      if (ph < BC) begin
        m_an   = 4'b1111;
        m_code = 4'hF;
      end else if (ph == BC) begin
        m_an = 4'b1111;
        m_an[slot] = 1'b0;
        dig = m_shadow[slot*4 +: 4];
        blk = (be && bm[slot] && (((m_frame / BF) % 2) == 1)) ||
              (slot == 3 && lz && dig == 4'd0);
        m_code = blk ? 4'hF : dig;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {4'b1111, 4'hF, 1'b0}) begin
        errs++;
        $display("FAIL reset_outputs got an=%b code=%h tick=%b want an=1111 code=f tick=0",
                 bus.an, bus.code_out, bus.frame_tick);
      end
    end
    vecs++;
    if (dut.pending !== 1'b0) begin
      errs++;
      $display("FAIL reset_pending got %b want 0", dut.pending);
    end
  endtask

  task automatic test_basic_scan();
    rst = 1'b0;
    bus.load = 1'b1; bus.digits_in = 16'h1234;
    step();
    bus.load = 1'b0;
    vecs++;
    if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
      errs++;
      $display("FAIL basic c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
               bus.frame_tick, m_an, m_code, m_tick);
    end
    repeat (3 * FRAME) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL basic c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
  endtask

  task automatic test_tear_free();
    int guard = 0;
    while (!(((c % FRAME) / SLOT == 1) && ((c % FRAME) % SLOT >= BC)) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    vecs++;
    if (guard >= 2 * FRAME) begin
      errs++;
      $display("FAIL tear_wait got timeout want digit1 SHOW");
    end
    bus.load = 1'b1; bus.digits_in = 16'h5678;
    step();
    bus.load = 1'b0;
    vecs++;
    if (dut.pending !== m_pending) begin
      errs++;
      $display("FAIL tear_pending got %b want %b", dut.pending, m_pending);
    end
    repeat (2 * FRAME) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL tear c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
  endtask

  task automatic test_coincident();
    int guard = 0;
    while ((c % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    vecs++;
    if (guard >= 2 * FRAME) begin
      errs++;
      $display("FAIL coinc_wait got timeout want pre-boundary cycle");
    end
    bus.load = 1'b1; bus.digits_in = 16'h9999;
    step();
    bus.load = 1'b0;
    vecs++;
    if (dut.pending !== 1'b0 || m_pending !== 1'b0) begin
      errs++;
      $display("FAIL coinc_pending got %b want 0", dut.pending);
    end
    repeat (FRAME + 6) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL coinc c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
  endtask

  task automatic test_blink();
    bus.blink_en = 1'b1; bus.blink_mask = 4'b0011;
    repeat (5 * FRAME) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL blink c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
    bus.blink_en = 1'b0; bus.blink_mask = 4'b0000;
  endtask

  task automatic test_lz_reset();
    int guard = 0;
    bus.lz_en = 1'b1;
    bus.load = 1'b1; bus.digits_in = 16'h0945;
    step();
    bus.load = 1'b0;
    repeat (2 * FRAME) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL lz c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
    while (!(((c % FRAME) / SLOT == 2) && ((c % FRAME) % SLOT >= BC)) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    vecs++;
    if (guard >= 2 * FRAME || bus.an !== 4'b1011) begin
      errs++;
      $display("FAIL lz_wait got an=%b want 1011 within bound", bus.an);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if ({bus.an, bus.code_out} !== {4'b1111, 4'hF}) begin
      errs++;
      $display("FAIL midreset got an=%b code=%h want an=1111 code=f", bus.an, bus.code_out);
    end
    repeat (BC + 2) begin
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL restart c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
    bus.lz_en = 1'b0;
  endtask

  task automatic test_random();
    repeat (600) begin
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.digits_in = 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        bus.blink_en   = 1'($urandom);
        bus.blink_mask = 4'($urandom);
        bus.lz_en      = 1'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
      vecs++;
      if ({bus.an, bus.code_out, bus.frame_tick} !== {m_an, m_code, m_tick}) begin
        errs++;
        $display("FAIL random c=%0d got %b/%h/%b want %b/%h/%b", c, bus.an, bus.code_out,
                 bus.frame_tick, m_an, m_code, m_tick);
      end
    end
    bus.load = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    vecs = 0; errs = 0; c = 0; m_frame = 0;
    m_shadow = '0; m_staging = '0; m_pending = 1'b0;
    m_an = 4'b1111; m_code = 4'hF; m_tick = 1'b0;
    rst = 1'b1;
    bus.load = 1'b0; bus.digits_in = 16'h0; bus.blink_en = 1'b0;
    bus.blink_mask = 4'h0; bus.lz_en = 1'b0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_coincident();
    test_blink();
    test_lz_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit is lit per slot; legal range 1 and up.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500: clk cycles of all-off dead time before each digit; legal range 1 and up.
REQ-003 SHALL have parameter BLINK_FRAMES, default 100: full scan frames per blink phase; legal range 1 and up.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port digits_in, input, 16 bits: four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-007 SHALL have port load, input, 1 bit: one-cycle strobe requesting capture of digits_in.
REQ-008 SHALL have port blink_en, input, 1 bit: enables blinking of the digits selected by blink_mask.
REQ-009 SHALL have port blink_mask, input, 4 bits: per-digit blink select.
REQ-010 SHALL have port lz_en, input, 1 bit: enables leading-zero blanking of digit 3.
REQ-011 SHALL have port code_out, output, 4 bits, registered: code fed to the seven-segment decoder; 4'hF produces an all-segments-off pattern.
REQ-012 SHALL have port an, output, 4 bits, registered, active low: digit enables; an[i] drives digit i.
REQ-013 SHALL have port frame_tick, output, 1 bit, registered: one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL implement a two-state FSM:
- BLANK: held for BLANK_CYCLES cycles, then SHOW.
- SHOW: held for SCAN_DIV cycles, then BLANK with the digit index advanced.
REQ-015 SHALL advance the digit index 0->1->2->3->0; one frame SHALL last 4*(BLANK_CYCLES+SCAN_DIV) cycles.
REQ-016 While in BLANK, an SHALL be 4'b1111 and code_out SHALL be 4'hF.
REQ-017 While in SHOW at index i, an SHALL have only bit i low, and code_out SHALL carry digit i of the shadow register, or 4'hF when that digit is blanked.
REQ-018 Outputs SHALL change on the same clock edge as the FSM state change; state-to-output latency is 0 cycles beyond the register stage.
REQ-019 A load strobe SHALL set a pending flag and latch digits_in into a staging register; a later load before the boundary SHALL overwrite the staging register (last load wins).
REQ-020 The shadow register SHALL update from staging only at a frame boundary, defined as the edge entering BLANK for index 0. The pending flag SHALL clear on that update. Mid-frame loads therefore never tear.
REQ-021 If load coincides with the boundary edge, the shadow register SHALL take digits_in directly, and pending SHALL end the edge clear.
REQ-022 frame_tick SHALL be high for exactly the one cycle after the boundary edge, including the first boundary after reset.
REQ-023 blink_phase SHALL toggle every BLINK_FRAMES frame boundaries, using an internal frame counter that wraps at BLINK_FRAMES-1.
REQ-024 Digit i SHALL be blanked when blink_en=1, blink_mask[i]=1 and blink_phase=1. Its an bit SHALL still go low; only code_out is forced to 4'hF.
REQ-025 Digit 3 SHALL be blanked when lz_en=1 and shadow digit 3 equals 0.
REQ-026 Digit values 10-15 SHALL pass through unmodified.
REQ-027 Changes to blink_en, blink_mask and lz_en SHALL take effect at the next SHOW entry; they do not alter a digit already lit.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL force:
- state=BLANK, index=0, slot counter=0, frame counter=0
- blink_phase=0, pending=0
- shadow and staging registers=16'h0000
- an=4'b1111, code_out=4'hF, frame_tick=0
REQ-029 Reset asserted mid-frame SHALL abort the scan immediately, with no partial SHOW cycle. After release, BLANK for index 0 SHALL restart with a full BLANK_CYCLES count.

Verification
REQ-030 The bench SHALL use SCAN_DIV=4, BLANK_CYCLES=2, BLINK_FRAMES=2, giving a frame of 24 cycles.
REQ-031 Scenario, basic scan: release rst, load digits_in=16'h1234 -> after the first boundary, each frame shows:
- 2 cycles an=1111/code=F, then 4 cycles an=1110/code=4
- then digit 1 (an=1101/code=3), digit 2 (an=1011/code=2), digit 3 (an=0111/code=1), each with the same 2+4 timing
- frame_tick pulses every 24 cycles.
REQ-032 Scenario, tear-free load: with 16'h1234 displayed, pulse load with 16'h5678 during digit 1 SHOW -> the rest of the frame still shows 3,2,1; the next frame shows 8,7,6,5.
REQ-033 Scenario, coincident load and boundary: pulse load=16'h9999 on the boundary edge -> the very next frame shows all 9s, and pending reads 0.
REQ-034 Scenario, blink: blink_en=1, blink_mask=4'b0011 -> digits 0 and 1 show their values for 2 frames, then code=F with an still low for 2 frames, alternating; digits 2 and 3 stay unaffected.
REQ-035 Scenario, leading zero and reset: shadow=16'h0945 with lz_en=1 -> digit 3 slot shows an=0111/code=F. Asserting rst during digit 2 SHOW -> the next edge gives an=1111/code=F, and after release the first SHOW is digit 0 after exactly 2 BLANK cycles.
